// File: rtl/servo_pkg.sv
// Shared constants and the servo-safe clamp helper for the servo PWM generator.
package servo_pkg;

    localparam int unsigned PWM_W         = 20;
    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned DEF_PERIOD    = 1_000_000;
    localparam int unsigned DEF_MIN_PULSE = 25_000;
    localparam int unsigned DEF_MAX_PULSE = 125_000;

    typedef struct packed {
        logic             hit;
        logic [PWM_W-1:0] value;
    } clamp_t;

    // Zero means "channel off" and passes through untouched; anything else is
    // forced into [min_p, max_p]. hit flags that the value was altered.
    function automatic clamp_t clamp_pulse(input logic [PWM_W-1:0] d,
                                           input logic [PWM_W-1:0] min_p,
                                           input logic [PWM_W-1:0] max_p);
        clamp_t r;
        r.hit   = 1'b0;
        r.value = d;
        if ((d != '0) && (d < min_p)) begin
            r.hit   = 1'b1;
            r.value = min_p;
        end else if (d > max_p) begin
            r.hit   = 1'b1;
            r.value = max_p;
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: frame-synchronous shadow of the clamped duty and the pulse comparator.
module servo_pwm_ch
    import servo_pkg::*;
#(
    parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
    parameter int unsigned MAX_PULSE = DEF_MAX_PULSE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] duty,
    input  logic             ch_en,
    output logic             pwm,
    output logic             clamp_hit
);

    localparam logic [PWM_W-1:0] MIN_V = PWM_W'(MIN_PULSE);
    localparam logic [PWM_W-1:0] MAX_V = PWM_W'(MAX_PULSE);

    logic [PWM_W-1:0] shadow;
    logic             en_sh;
    clamp_t           clamp_c;

    // Clamp the live request so it is ready whenever a load happens.
    always_comb begin
        clamp_c = clamp_pulse(duty, MIN_V, MAX_V);
    end

    // Shadow update only on load; pulse is high while the frame count is below the shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            en_sh     <= 1'b0;
            clamp_hit <= 1'b0;
            pwm       <= 1'b0;
        end else begin
            if (load) begin
                shadow    <= clamp_c.value;
                en_sh     <= ch_en;
                clamp_hit <= clamp_c.hit;
            end
            pwm <= en && en_sh && (cnt < shadow);
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Multi-channel servo PWM generator: shared frame counter, frame-boundary loads, registered pulses.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned N_CH      = 6,
    parameter int unsigned PERIOD    = DEF_PERIOD,
    parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
    parameter int unsigned MAX_PULSE = DEF_MAX_PULSE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_CH*PWM_W-1:0] duty_in,
    input  logic [N_CH-1:0]       ch_en,
    output logic [N_CH-1:0]       pwm_out,
    output logic                  frame_start,
    output logic [N_CH-1:0]       clamp_hit
);

    localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(PERIOD - 1);

    logic [PWM_W-1:0] cnt;
    logic             load_c;

    // While idle the shadows track the inputs; while running they load only at frame end.
    assign load_c = !en || (cnt == CNT_LAST);

    // Frame counter: held at zero while idle, wraps at PERIOD-1.
    always_ff @(posedge clk) begin
        if (rst || !en || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PWM_W'(1);
        end
    end

    // Frame strobe aligned with the first output cycle of each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= en && (cnt == '0);
        end
    end

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        servo_pwm_ch #(
            .MIN_PULSE (MIN_PULSE),
            .MAX_PULSE (MAX_PULSE)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .load      (load_c),
            .cnt       (cnt),
            .duty      (duty_in[i*PWM_W +: PWM_W]),
            .ch_en     (ch_en[i]),
            .pwm       (pwm_out[i]),
            .clamp_hit (clamp_hit[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: directed frame scenarios plus randomized traffic vs. a frame-level model.
module tb_servo_pwm_gen;
    import servo_pkg::*;

    localparam int unsigned N_CH   = 2;
    localparam int unsigned PERIOD = 100;
    localparam int unsigned MIN_P  = 10;
    localparam int unsigned MAX_P  = 50;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [N_CH*PWM_W-1:0] duty_in;
    logic [N_CH-1:0]       ch_en;
    logic [N_CH-1:0]       pwm_out;
    logic                  frame_start;
    logic [N_CH-1:0]       clamp_hit;

    int checks = 0;
    int errors = 0;

    // Reference model: enabled-cycle count since last idle/reset, plus the values latched for the frame.
    int              run_len = 0;
    int              lat_val [N_CH];
    logic [N_CH-1:0] lat_en  = '0;
    logic [N_CH-1:0] lat_hit = '0;
    logic [N_CH-1:0] exp_pwm = '0;
    logic            exp_fs  = 1'b0;

    always #5 clk = ~clk;

    servo_pwm_gen #(
        .N_CH      (N_CH),
        .PERIOD    (PERIOD),
        .MIN_PULSE (MIN_P),
        .MAX_PULSE (MAX_P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .duty_in     (duty_in),
        .ch_en       (ch_en),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .clamp_hit   (clamp_hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_clamp(input int d);
        if (d == 0) return 0;
        if (d < int'(MIN_P)) return int'(MIN_P);
        if (d > int'(MAX_P)) return int'(MAX_P);
        return d;
    endfunction

    task automatic set_duty(input int ch, input int v);
        duty_in[ch*PWM_W +: PWM_W] = PWM_W'(v);
    endtask

    // One clock with the current inputs; advance the model and compare every output.
    task automatic step();
        int pos;
        int d;
        @(posedge clk);
        if (rst) begin
            run_len = 0;
            for (int i = 0; i < int'(N_CH); i++) lat_val[i] = 0;
            lat_en  = '0;
            lat_hit = '0;
            exp_pwm = '0;
            exp_fs  = 1'b0;
        end else begin
            pos = run_len % int'(PERIOD);
            exp_fs = en && (pos == 0);
            for (int i = 0; i < int'(N_CH); i++)
                exp_pwm[i] = en && lat_en[i] && (pos < lat_val[i]);
            if (!en || pos == int'(PERIOD) - 1) begin
                for (int i = 0; i < int'(N_CH); i++) begin
                    d          = int'(duty_in[i*PWM_W +: PWM_W]);
                    lat_val[i] = ref_clamp(d);
                    lat_en[i]  = ch_en[i];
                    lat_hit[i] = (ref_clamp(d) != d);
                end
            end
            run_len = en ? run_len + 1 : 0;
        end
        #1;
        check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        check("clamp_hit", 32'(clamp_hit), 32'(lat_hit));
    endtask

    task automatic run_frames(input int n);
        repeat (n * int'(PERIOD)) step();
    endtask

    // Find the next frame_start (bounded) and count channel high cycles over that frame.
    // Optionally change duty0/ch_en0 after chg_pos cycles into the frame.
    task automatic measure(input string tag, input int ch, input int exp_hi,
                           input int chg_pos, input int new_d0, input logic new_chen0);
        int  hi;
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 2 * int'(PERIOD) && !seen; k++) begin
            step();
            if (frame_start) seen = 1'b1;
        end
        check({tag, "_fs_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        check({tag, "_rise"}, 32'(pwm_out[ch]), 32'(exp_hi != 0));
        hi = int'(pwm_out[ch]);
        for (int k = 1; k < int'(PERIOD); k++) begin
            if (k - 1 == chg_pos) begin
                set_duty(0, new_d0);
                ch_en[0] = new_chen0;
            end
            step();
            hi += int'(pwm_out[ch]);
        end
        check({tag, "_width"}, 32'(hi), 32'(exp_hi));
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        ch_en   = '0;
        duty_in = '0;
        step();
        step();
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_fs", 32'(frame_start), 32'd0);
        check("reset_hit", 32'(clamp_hit), 32'd0);

        // Basic pulses: first frame uses reset shadows (low), then 20/35.
        rst   = 1'b0;
        en    = 1'b1;
        ch_en = 2'b11;
        set_duty(0, 20);
        set_duty(1, 35);
        measure("s1_first", 0, 0, -1, 20, 1'b1);
        measure("s1_ch0", 0, 20, -1, 20, 1'b1);
        measure("s1_ch1", 1, 35, -1, 20, 1'b1);

        // Clamping at both limits and the zero pass-through.
        set_duty(0, 5);
        run_frames(1);
        measure("s2_min", 0, 10, -1, 5, 1'b1);
        check("s2_min_hit", 32'(clamp_hit[0]), 32'd1);
        set_duty(0, 70);
        run_frames(1);
        measure("s2_max", 0, 50, -1, 70, 1'b1);
        check("s2_max_hit", 32'(clamp_hit[0]), 32'd1);
        set_duty(0, 0);
        run_frames(1);
        measure("s2_zero", 0, 0, -1, 0, 1'b1);
        check("s2_zero_hit", 32'(clamp_hit[0]), 32'd0);

        // Mid-frame duty change only takes effect next frame.
        set_duty(0, 20);
        run_frames(1);
        measure("s3_cur", 0, 20, 30, 40, 1'b1);
        measure("s3_next", 0, 40, -1, 40, 1'b1);

        // Mid-frame channel disable lets the current pulse finish.
        set_duty(0, 20);
        run_frames(1);
        measure("s4_cur", 0, 20, 5, 20, 1'b0);
        measure("s4_next", 0, 0, -1, 20, 1'b0);

        // Stop mid-pulse, then restart with values captured while idle.
        ch_en = 2'b11;
        run_frames(1);
        measure("s5_pre", 0, 20, -1, 20, 1'b1);
        repeat (10) step();
        en = 1'b0;
        step();
        check("s5_stop_pwm", 32'(pwm_out), 32'd0);
        check("s5_stop_fs", 32'(frame_start), 32'd0);
        repeat (5) step();
        en = 1'b1;
        step();
        check("s5_restart_fs", 32'(frame_start), 32'd1);
        check("s5_restart_pwm", 32'(pwm_out), 32'b11);

        // Reset mid-pulse clears everything; counter restarts.
        repeat (14) step();
        rst = 1'b1;
        step();
        check("s6_rst_pwm", 32'(pwm_out), 32'd0);
        check("s6_rst_fs", 32'(frame_start), 32'd0);
        check("s6_rst_hit", 32'(clamp_hit), 32'd0);
        rst = 1'b0;
        step();
        check("s6_after_fs", 32'(frame_start), 32'd1);
        check("s6_after_pwm", 32'(pwm_out), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    set_duty(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, (1 << PWM_W) - 1)));
                else
                    set_duty(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 70)));
            end
            if ($urandom_range(0, 149) == 0) ch_en[$urandom_range(0, N_CH - 1)] ^= 1'b1;
            if ($urandom_range(0, 299) == 0) en = ~en;
            rst = ($urandom_range(0, 999) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
